// File: rtl/cr16_run_control.sv
// cr16_run_control: warm-up, run/step/breakpoint control, cycle counter and display mux for the CR16 core
module cr16_run_control #(
  parameter int P_COLD_CLK_CYCLES = 2,
  parameter int P_MAX_PC = 32,
  parameter int P_PC_WIDTH = 16,
  parameter int P_DATA_WIDTH = 16,
  parameter int P_NUM_DIGITS = 6,
  parameter int P_CNT_WIDTH = 24
) (
  input  logic I_CLK,
  input  logic I_RESET,
  input  logic [1:0] I_MODE,
  input  logic I_STEP,
  input  logic I_RESUME,
  input  logic [P_PC_WIDTH-1:0] I_BREAK_PC,
  input  logic [P_PC_WIDTH-1:0] I_PC,
  input  logic [P_DATA_WIDTH-1:0] I_RESULT_BUS,
  input  logic [P_DATA_WIDTH-1:0] I_MEM_DATA_B,
  output logic O_CR16_ENABLE,
  output logic [4*P_NUM_DIGITS-1:0] O_DISPLAY_BITS,
  output logic [2:0] O_STATE,
  output logic O_HALTED,
  output logic [P_CNT_WIDTH-1:0] O_CYCLE_COUNT
);
  typedef enum logic [2:0] {
    WARMUP = 3'd0,
    RUN = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_PULSE = 3'd3,
    HALT_BRK = 3'd4,
    HALT_MAX = 3'd5
  } state_t;
  localparam int unsigned COLD = (P_COLD_CLK_CYCLES < 1) ? 1 : P_COLD_CLK_CYCLES;
  localparam int DW = 4 * P_NUM_DIGITS;
  state_t state_q, state_n;
  logic [31:0] wcnt_q;
  logic step_q, resume_q, mask_q;
  logic step_rise, resume_rise, max_hit, brk_hit, halt_n;
  assign step_rise = I_STEP & ~step_q;
  assign resume_rise = I_RESUME & ~resume_q;
  assign max_hit = 32'(I_PC) > 32'(P_MAX_PC);
  assign brk_hit = (I_MODE == 2'b10) && (I_PC == I_BREAK_PC) && !mask_q;
  assign halt_n = (state_n == HALT_BRK) || (state_n == HALT_MAX);
  assign O_STATE = state_q;
  // next state and core enable; enable is gated combinationally so a halting PC never executes
  always_comb begin
    state_n = state_q;
    O_CR16_ENABLE = 1'b0;
    case (state_q)
      WARMUP: state_n = (wcnt_q == 32'(COLD - 1)) ? ((I_MODE == 2'b01) ? STEP_WAIT : RUN) : WARMUP;
      RUN: begin
        O_CR16_ENABLE = !max_hit && !brk_hit;
        state_n = max_hit ? HALT_MAX : brk_hit ? HALT_BRK : (I_MODE == 2'b01) ? STEP_WAIT : RUN;
      end
      STEP_WAIT: state_n = max_hit ? HALT_MAX : step_rise ? STEP_PULSE : (I_MODE != 2'b01) ? RUN : STEP_WAIT;
      STEP_PULSE: begin
        O_CR16_ENABLE = !max_hit;
        state_n = STEP_WAIT;
      end
      HALT_BRK: state_n = resume_rise ? RUN : HALT_BRK;
      HALT_MAX: state_n = HALT_MAX;
      default: state_n = WARMUP;
    endcase
  end
  // state, warm-up count, edge detectors and the breakpoint mask that suppresses re-halting on resume
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= WARMUP;
      wcnt_q <= '0;
      step_q <= 1'b0;
      resume_q <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      state_q <= state_n;
      if (state_q == WARMUP) wcnt_q <= wcnt_q + 32'd1;
      step_q <= I_STEP;
      resume_q <= I_RESUME;
      if (state_q == HALT_BRK && resume_rise) mask_q <= 1'b1;
      else if (I_PC != I_BREAK_PC || I_MODE != 2'b10) mask_q <= 1'b0;
    end
  end
  // registered outputs: display source follows the current state, halted tracks the next state
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      O_DISPLAY_BITS <= '0;
      O_HALTED <= 1'b0;
      O_CYCLE_COUNT <= '0;
    end else begin
      O_DISPLAY_BITS <= (state_q == HALT_BRK || state_q == HALT_MAX) ? DW'(I_MEM_DATA_B) : DW'({I_PC, I_RESULT_BUS});
      O_HALTED <= halt_n;
      if (O_CR16_ENABLE && !(&O_CYCLE_COUNT)) O_CYCLE_COUNT <= O_CYCLE_COUNT + P_CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_cr16_run_control.sv
// tb_cr16_run_control: directed checks of warm-up, halts, breakpoint resume, stepping, display and saturation
module tb_cr16_run_control;
  logic I_CLK = 1'b0;
  logic I_RESET, I_STEP, I_RESUME;
  logic [1:0] I_MODE;
  logic [15:0] I_BREAK_PC, I_PC, I_RESULT_BUS, I_MEM_DATA_B;
  logic en, halted, s_en, s_halted;
  logic [23:0] disp, s_disp, cnt;
  logic [2:0] state, s_state;
  logic [3:0] s_cnt;
  int checks = 0;
  int errors = 0;
  always #5 I_CLK = ~I_CLK;
  cr16_run_control dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_MODE(I_MODE), .I_STEP(I_STEP), .I_RESUME(I_RESUME),
    .I_BREAK_PC(I_BREAK_PC), .I_PC(I_PC), .I_RESULT_BUS(I_RESULT_BUS), .I_MEM_DATA_B(I_MEM_DATA_B),
    .O_CR16_ENABLE(en), .O_DISPLAY_BITS(disp), .O_STATE(state), .O_HALTED(halted), .O_CYCLE_COUNT(cnt)
  );
  cr16_run_control #(.P_CNT_WIDTH(4)) sat (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_MODE(I_MODE), .I_STEP(I_STEP), .I_RESUME(I_RESUME),
    .I_BREAK_PC(I_BREAK_PC), .I_PC(I_PC), .I_RESULT_BUS(I_RESULT_BUS), .I_MEM_DATA_B(I_MEM_DATA_B),
    .O_CR16_ENABLE(s_en), .O_DISPLAY_BITS(s_disp), .O_STATE(s_state), .O_HALTED(s_halted), .O_CYCLE_COUNT(s_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge I_CLK);
    #2;
  endtask
  initial begin
    I_RESET = 1'b1; I_MODE = 2'b00; I_STEP = 1'b0; I_RESUME = 1'b0;
    I_BREAK_PC = 16'd8; I_PC = 16'd0; I_RESULT_BUS = 16'd0; I_MEM_DATA_B = 16'hBEEF;
    cyc();
    chk("rst_state", 32'(state), 0);
    chk("rst_disp", 32'(disp), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_count", 32'(cnt), 0);
    I_RESET = 1'b0; #1;
    chk("warm_en0", 32'(en), 0);
    cyc(); #1;
    chk("warm_en1", 32'(en), 0);
    chk("warm_state", 32'(state), 0);
    cyc(); #1;
    chk("run_state", 32'(state), 1);
    chk("run_en", 32'(en), 1);
    chk("run_count0", 32'(cnt), 0);
    for (int i = 1; i <= 21; i++) begin
      cyc();
      chk("run_count", 32'(cnt), 32'(i));
      chk("sat_count", 32'(s_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    I_PC = 16'h0012; I_RESULT_BUS = 16'h4567; #1;
    chk("disp_en", 32'(en), 1);
    cyc();
    chk("disp_pack", 32'(disp), 32'h124567);
    I_PC = 16'd31; #1;
    chk("pc31_en", 32'(en), 1);
    cyc();
    I_PC = 16'd32; #1;
    chk("pc32_en", 32'(en), 1);
    cyc();
    I_PC = 16'h0123; #1;
    chk("pc33_en", 32'(en), 0);
    chk("pc33_state", 32'(state), 1);
    cyc();
    chk("hmax_state", 32'(state), 5);
    chk("hmax_halted", 32'(halted), 1);
    chk("hmax_disp_run", 32'(disp), 32'h234567);
    chk("hmax_count", 32'(cnt), 24);
    chk("sat_hold", 32'(s_cnt), 15);
    cyc();
    chk("hmax_disp_mem", 32'(disp), 32'h00BEEF);
    I_RESUME = 1'b1; I_STEP = 1'b1;
    cyc(); cyc(); #1;
    chk("hmax_resume_state", 32'(state), 5);
    chk("hmax_resume_en", 32'(en), 0);
    chk("hmax_resume_count", 32'(cnt), 24);
    I_RESUME = 1'b0; I_STEP = 1'b0;
    I_RESET = 1'b1;
    cyc();
    chk("rst_hmax_state", 32'(state), 0);
    chk("rst_hmax_halted", 32'(halted), 0);
    chk("rst_hmax_disp", 32'(disp), 0);
    chk("rst_hmax_count", 32'(cnt), 0);
    chk("rst_hmax_sat", 32'(s_cnt), 0);
    I_RESET = 1'b0; I_PC = 16'd0; I_MODE = 2'b10;
    cyc(); cyc();
    chk("brk_run_state", 32'(state), 1);
    I_PC = 16'd7; #1;
    chk("brk_pc7_en", 32'(en), 1);
    cyc();
    I_PC = 16'd8; #1;
    chk("brk_pc8_en", 32'(en), 0);
    cyc();
    chk("brk_state", 32'(state), 4);
    chk("brk_halted", 32'(halted), 1);
    cyc();
    chk("brk_disp", 32'(disp), 32'h00BEEF);
    chk("brk_count", 32'(cnt), 1);
    I_RESUME = 1'b1; #1;
    chk("brk_resume_en0", 32'(en), 0);
    cyc(); #1;
    chk("resume_state", 32'(state), 1);
    chk("resume_halted", 32'(halted), 0);
    chk("resume_en", 32'(en), 1);
    cyc();
    chk("resume_norehalt", 32'(state), 1);
    chk("resume_count", 32'(cnt), 2);
    I_PC = 16'd9; #1;
    chk("pc9_en", 32'(en), 1);
    cyc();
    I_PC = 16'd8; #1;
    chk("rebrk_en", 32'(en), 0);
    cyc();
    chk("rebrk_state", 32'(state), 4);
    I_RESUME = 1'b0;
    I_RESET = 1'b1;
    cyc();
    I_RESET = 1'b0; I_PC = 16'd0; I_MODE = 2'b01;
    cyc(); cyc(); #1;
    chk("step_wait_state", 32'(state), 2);
    chk("step_wait_en", 32'(en), 0);
    I_STEP = 1'b1;
    cyc(); #1;
    chk("step_pulse_state", 32'(state), 3);
    chk("step_pulse_en", 32'(en), 1);
    cyc(); #1;
    chk("step_back_state", 32'(state), 2);
    chk("step_back_en", 32'(en), 0);
    chk("step_count1", 32'(cnt), 1);
    cyc(); cyc(); cyc();
    chk("step_held_state", 32'(state), 2);
    chk("step_held_count", 32'(cnt), 1);
    I_STEP = 1'b0;
    cyc();
    I_STEP = 1'b1;
    cyc(); #1;
    chk("step2_en", 32'(en), 1);
    cyc();
    chk("step2_count", 32'(cnt), 2);
    I_STEP = 1'b0;
    cyc();
    I_STEP = 1'b1;
    cyc();
    chk("step3_state", 32'(state), 3);
    I_RESET = 1'b1;
    cyc();
    chk("rst_step_state", 32'(state), 0);
    chk("rst_step_count", 32'(cnt), 0);
    chk("rst_step_halted", 32'(halted), 0);
    chk("rst_step_disp", 32'(disp), 0);
    I_RESET = 1'b0; I_STEP = 1'b0; I_MODE = 2'b11;
    cyc(); cyc(); #1;
    chk("mode11_state", 32'(state), 1);
    chk("mode11_en", 32'(en), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cr16_run_control.md
Name: cr16_run_control

Overview:
- Parametrised run controller between the CR16 core and board I/O.
- Generalises the fixed warm-up, max-PC halt and display logic of the current top level.
- Adds the following:
  - a clock-enable output instead of a gated clock
  - single-step mode
  - a PC breakpoint with resume
  - a saturating executed-cycle counter
  - configurable display width
- Instantiated by the board top; drives the core's I_ENABLE and the seven-segment mapping bus.

Parameters:
- P_COLD_CLK_CYCLES, 2: warm-up cycles after reset with the core disabled; values below 1 are treated as 1.
- P_MAX_PC, 32: the core halts permanently once PC > P_MAX_PC.
- P_PC_WIDTH, 16: width of the PC and breakpoint address.
- P_DATA_WIDTH, 16: width of the result bus and memory port B data.
- P_NUM_DIGITS, 6: number of hex digits; requires 4*P_NUM_DIGITS >= P_DATA_WIDTH.
- P_CNT_WIDTH, 24: width of the executed-cycle counter.

Ports:
- I_CLK, input, 1: system clock, rising edge.
- I_RESET, input, 1: synchronous, active-high reset.
- I_MODE, input, 2: 00 free-run, 01 single-step, 10 breakpoint-run, 11 treated as 00.
- I_STEP, input, 1: step request, level; rising edge detected internally.
- I_RESUME, input, 1: resume request, level; rising edge detected internally.
- I_BREAK_PC, input, P_PC_WIDTH: breakpoint address.
- I_PC, input, P_PC_WIDTH: current core PC.
- I_RESULT_BUS, input, P_DATA_WIDTH: core result bus.
- I_MEM_DATA_B, input, P_DATA_WIDTH: BRAM port B read data.
- O_CR16_ENABLE, output, 1: core enable (combinational).
- O_DISPLAY_BITS, output, 4*P_NUM_DIGITS: packed hex nibbles, digit 0 in the LSBs (registered).
- O_STATE, output, 3: current state encoding.
- O_HALTED, output, 1: high in HALT_MAX or HALT_BRK (registered).
- O_CYCLE_COUNT, output, P_CNT_WIDTH: number of enabled cycles, saturating (registered).

Behaviour:

States (O_STATE encoding): WARMUP=0, RUN=1, STEP_WAIT=2, STEP_PULSE=3, HALT_BRK=4, HALT_MAX=5.

Reset (I_RESET high at a rising edge):
- state = WARMUP, warm-up counter = 0.
- O_DISPLAY_BITS = 0, O_HALTED = 0, O_CYCLE_COUNT = 0.
- Edge-detect registers cleared, breakpoint mask cleared.
- Reset takes priority over all other events, including mid-step and mid-halt.

Conditions used below:
- max_hit = (I_PC > P_MAX_PC), unsigned.
- brk_hit = (I_MODE == 10) && (I_PC == I_BREAK_PC) && !mask.

O_CR16_ENABLE:
- RUN: high when !max_hit && !brk_hit.
- STEP_PULSE: high when !max_hit.
- All other states: low.
- The check is combinational, so the core never executes an instruction at a halting PC.

WARMUP:
- Counter increments each cycle.
- After P_COLD_CLK_CYCLES cycles, go to STEP_WAIT if I_MODE == 01, otherwise RUN.

RUN:
- max_hit → HALT_MAX (takes priority over brk_hit).
- Else brk_hit → HALT_BRK.
- Else I_MODE == 01 → STEP_WAIT.

STEP_WAIT:
- max_hit → HALT_MAX.
- Else I_STEP rising edge → STEP_PULSE.
- Else I_MODE != 01 → RUN.
- The breakpoint is ignored in step mode.

STEP_PULSE:
- Lasts exactly one cycle, then → STEP_WAIT.
- A held I_STEP produces only one pulse.

HALT_BRK:
- I_RESUME rising edge → RUN and set mask.
- The mask clears the first cycle I_PC != I_BREAK_PC, or when I_MODE leaves 10.
- This prevents an immediate re-halt at the same PC.

HALT_MAX:
- Terminal; only I_RESET leaves it. I_RESUME and I_STEP are ignored.

Edge detection:
- 1-flop previous-value register per input.
- An edge present on the same cycle as reset is discarded.

O_DISPLAY_BITS (registered, 1-cycle latency):
- HALT states: zero-extended I_MEM_DATA_B.
- All other states: I_RESULT_BUS in bits [P_DATA_WIDTH-1:0]; the remaining upper bits hold the low bits of I_PC, zero-padded if I_PC is narrower.
- Defaults give {PC[7:0], RESULT}.

O_CYCLE_COUNT:
- +1 on each cycle O_CR16_ENABLE is high.
- Holds at all-ones and never wraps.

O_HALTED:
- Registered version of the next state being a halt state; high the cycle the state register enters HALT.

Test Plan:
- Warm-up/free-run: reset 1 cycle, I_MODE=00, I_PC=0 → enable low for exactly 2 cycles, then high; O_STATE=1; O_CYCLE_COUNT increments by 1 per cycle.
- Max-PC halt: in RUN, drive I_PC 31, 32, 33 → enable high at 31 and 32, low in the same cycle I_PC=33; next cycle O_STATE=5, O_HALTED=1; display = 0x00_xxxx taken from I_MEM_DATA_B (e.g. 0xBEEF → 0x00BEEF); I_RESUME pulse → no change.
- Breakpoint and resume: I_MODE=10, I_BREAK_PC=8:
  - I_PC reaches 8 → enable low, O_STATE=4.
  - Resume edge → enable high with I_PC still 8, no re-halt.
  - I_PC goes 9 then back to 8 → halts again.
- Single-step: I_MODE=01, I_STEP held high for 5 cycles → exactly one enable-high cycle, O_CYCLE_COUNT +1; release and press again → a second single pulse.
- Display packing: RUN, I_PC=0x0123, I_RESULT_BUS=0x4567 → O_DISPLAY_BITS=0x234567 one cycle later.
- Reset mid-operation and saturation:
  - Assert I_RESET during STEP_PULSE or HALT_MAX → next cycle WARMUP, all outputs 0.
  - With P_CNT_WIDTH=4, run 20 enabled cycles → O_CYCLE_COUNT stays at 0xF.
